// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fetch_pkg;

    typedef enum logic [1:0] {
        FETCH_IDLE,
        FETCH_RUN,
        FETCH_HALTED
    } fetch_state_e;

    // Instruction word that stops fetching when the halt-opcode feature is built in
    localparam logic [8:0] HALT_OPCODE = 9'h1FF;

endpackage

// File: rtl/fetch_out_reg.sv
// Output register toward decode: holds one instruction and the PC it came from.
// Latency: load at edge T is visible after T; flush clears valid at the same edge.
// Backpressure: data/PC are held stable while out_vld && !out_rdy; flush wins over load.
module fetch_out_reg #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 9
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  load,
    input  logic [DATA_WIDTH-1:0] in_dat,
    input  logic [ADDR_WIDTH-1:0] in_pc,
    input  logic                  out_rdy,
    output logic                  out_vld,
    output logic [DATA_WIDTH-1:0] out_dat,
    output logic [ADDR_WIDTH-1:0] out_pc
);

    // Valid flag plus payload; payload only changes on a load so a stall freezes it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_vld <= 1'b0;
            out_dat <= '0;
            out_pc  <= '0;
        end else if (flush) begin
            out_vld <= 1'b0;
        end else if (load) begin
            out_vld <= 1'b1;
            out_dat <= in_dat;
            out_pc  <= in_pc;
        end else if (out_rdy) begin
            // Drained by decode with nothing new behind it
            out_vld <= 1'b0;
        end
    end

endmodule

// File: rtl/instr_fetch_ctrl.sv
// PC sequencer: walks the fetch address, redirects on branches, feeds decode.
// Latency: start at T -> first instruction valid after T+1; one per cycle; branch costs one bubble.
// Backpressure: instr_valid && !instr_ready freezes PC and the output register.
// Optional: FETCH_HALT_OPCODE_EN makes fetching HALT_OPCODE halt instead of delivering it.
module instr_fetch_ctrl
    import fetch_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 10,
    parameter int                    DATA_WIDTH = 9,
    parameter logic [ADDR_WIDTH-1:0] START_ADDR = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  branch_valid,
    input  logic [ADDR_WIDTH-1:0] branch_target,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_instr,
    output logic                  instr_valid,
    input  logic                  instr_ready,
    output logic [DATA_WIDTH-1:0] instr_data,
    output logic [ADDR_WIDTH-1:0] instr_pc,
    output logic                  busy,
    output logic                  done,
    output logic                  pc_wrap
);

    fetch_state_e          state, state_nxt;
    logic [ADDR_WIDTH-1:0] pc, pc_nxt;
    logic                  wrap_nxt;
    logic                  out_flush;
    logic                  out_load;
    logic                  fetch_ok;

    assign fetch_ok = !instr_valid || instr_ready;
    assign mem_addr = pc;
    assign busy     = (state == FETCH_RUN);
    assign done     = (state == FETCH_HALTED);

    // State, PC and sticky wrap flag registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= FETCH_IDLE;
            pc      <= START_ADDR;
            pc_wrap <= 1'b0;
        end else begin
            state   <= state_nxt;
            pc      <= pc_nxt;
            pc_wrap <= wrap_nxt;
        end
    end

    // Next state and PC: stop beats branch beats fetch/stall while running
    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        wrap_nxt  = pc_wrap;
        out_flush = 1'b0;
        out_load  = 1'b0;
        case (state)
            FETCH_IDLE, FETCH_HALTED: begin
                if (start) begin
                    state_nxt = FETCH_RUN;
                    pc_nxt    = START_ADDR;
                    wrap_nxt  = 1'b0;
                    out_flush = 1'b1;
                end
            end
            FETCH_RUN: begin
                if (stop) begin
                    state_nxt = FETCH_HALTED;
                    out_flush = 1'b1;
                end else if (branch_valid) begin
                    pc_nxt    = branch_target;
                    out_flush = 1'b1;
                end else if (fetch_ok) begin
`ifdef FETCH_HALT_OPCODE_EN
                    if (mem_instr == DATA_WIDTH'(HALT_OPCODE)) begin
                        // PC stays on the halt word; nothing is presented to decode
                        state_nxt = FETCH_HALTED;
                        out_flush = 1'b1;
                    end else begin
                        out_load = 1'b1;
                        pc_nxt   = pc + 1'b1;
                        if (&pc) wrap_nxt = 1'b1;
                    end
`else
                    out_load = 1'b1;
                    pc_nxt   = pc + 1'b1;
                    if (&pc) wrap_nxt = 1'b1;
`endif
                end
            end
            default: state_nxt = FETCH_IDLE;
        endcase
    end

    fetch_out_reg #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_out_reg (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush   (out_flush),
        .load    (out_load),
        .in_dat  (mem_instr),
        .in_pc   (pc),
        .out_rdy (instr_ready),
        .out_vld (instr_valid),
        .out_dat (instr_data),
        .out_pc  (instr_pc)
    );

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Self-checking bench for instr_fetch_ctrl against a cycle-level behavioural model.
// Latency: n/a.
// Backpressure: instr_ready is driven directly and randomised.
module tb_instr_fetch_ctrl;

    localparam int              AW    = 10;
    localparam int              DW    = 9;
    localparam int              DEPTH = 1 << AW;
    localparam logic [AW-1:0]   START = 10'h000;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          stop = 1'b0;
    logic          branch_valid = 1'b0;
    logic [AW-1:0] branch_target = '0;
    logic          instr_ready = 1'b0;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_instr;
    logic          instr_valid;
    logic [DW-1:0] instr_data;
    logic [AW-1:0] instr_pc;
    logic          busy;
    logic          done;
    logic          pc_wrap;

    logic [DW-1:0] mem [0:DEPTH-1];

    int n_chk  = 0;
    int n_fail = 0;

    // Behavioural model state
    bit m_busy, m_done, m_vld, m_wrap;
    int m_pc, m_ipc, m_data;

    always #5 clk = ~clk;

    // Combinational instruction memory
    assign mem_instr = mem[mem_addr];

    instr_fetch_ctrl #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .START_ADDR (START)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .stop          (stop),
        .branch_valid  (branch_valid),
        .branch_target (branch_target),
        .mem_addr      (mem_addr),
        .mem_instr     (mem_instr),
        .instr_valid   (instr_valid),
        .instr_ready   (instr_ready),
        .instr_data    (instr_data),
        .instr_pc      (instr_pc),
        .busy          (busy),
        .done          (done),
        .pc_wrap       (pc_wrap)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    task automatic model_reset();
        m_busy = 0; m_done = 0; m_vld = 0; m_wrap = 0;
        m_pc = int'(START); m_ipc = 0; m_data = 0;
    endtask

    // One clock edge of the fetch rules applied to the current inputs
    task automatic model_edge();
        int word;
        if (!m_busy) begin
            if (start) begin
                m_busy = 1; m_done = 0; m_pc = int'(START); m_wrap = 0; m_vld = 0;
            end
        end else if (stop) begin
            m_busy = 0; m_done = 1; m_vld = 0;
        end else if (branch_valid) begin
            m_pc = int'(branch_target); m_vld = 0;
        end else if (!m_vld || instr_ready) begin
            word = int'(mem[m_pc]);
`ifdef FETCH_HALT_OPCODE_EN
            if (word == 'h1FF) begin
                m_busy = 0; m_done = 1; m_vld = 0;
                return;
            end
`endif
            m_data = word; m_ipc = m_pc; m_vld = 1;
            if (m_pc == DEPTH - 1) m_wrap = 1;
            m_pc = (m_pc + 1) % DEPTH;
        end
    endtask

    task automatic cmp_all();
        check("mem_addr",    32'(mem_addr),    32'(m_pc));
        check("instr_valid", 32'(instr_valid), 32'(m_vld));
        check("instr_data",  32'(instr_data),  32'(m_data));
        check("instr_pc",    32'(instr_pc),    32'(m_ipc));
        check("busy",        32'(busy),        32'(m_busy));
        check("done",        32'(done),        32'(m_done));
        check("pc_wrap",     32'(pc_wrap),     32'(m_wrap));
    endtask

    // Apply inputs at a falling edge, advance one rising edge, compare after it
    task automatic cyc(input bit st, input bit sp, input bit bv, input int bt, input bit rdy);
        start         = st;
        stop          = sp;
        branch_valid  = bv;
        branch_target = AW'(bt);
        instr_ready   = rdy;
        model_edge();
        @(posedge clk);
        #1;
        cmp_all();
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = DW'($urandom);
        for (int i = 0; i < 5; i++) mem[i] = DW'(i + 1);
        model_reset();

        // Reset values
        #1;
        cmp_all();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Idle, then start and stream words 1..5 with ready high
        cyc(0, 0, 0, 0, 1);
        cyc(1, 0, 0, 0, 1);
        repeat (3) cyc(0, 0, 0, 0, 1);
        // Stall three cycles holding mem[2] at PC 2, then resume
        repeat (3) cyc(0, 0, 0, 0, 0);
        repeat (3) cyc(0, 0, 0, 0, 1);
        // Branch during a handshake, one bubble, then 200, 201
        cyc(0, 0, 1, 'h200, 1);
        repeat (3) cyc(0, 0, 0, 0, 1);
        // Address wrap 3FE, 3FF, 000
        cyc(0, 0, 1, 'h3FE, 1);
        repeat (5) cyc(0, 0, 0, 0, 1);
        // Stop and branch together, then stop/branch ignored while halted
        cyc(0, 1, 1, 'h100, 1);
        cyc(0, 1, 1, 'h155, 1);
        cyc(0, 0, 0, 0, 1);
        // Restart clears wrap; start while running is ignored
        cyc(1, 0, 0, 0, 1);
        repeat (2) cyc(0, 0, 0, 0, 1);
        cyc(1, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 1);

        // Randomised control and backpressure
        for (int i = 0; i < 1500; i++) begin
            cyc($urandom_range(0, 19) == 0,
                $urandom_range(0, 59) == 0,
                $urandom_range(0, 14) == 0,
                int'($urandom_range(0, DEPTH - 1)),
                $urandom_range(0, 3) != 0);
        end

`ifdef FETCH_HALT_OPCODE_EN
        // Halt word at address 3: words 0..2 delivered, then halted
        for (int i = 0; i < 3; i++) mem[i] = DW'(i + 1);
        mem[3] = 9'h1FF;
        cyc(0, 1, 0, 0, 1);
        cyc(1, 0, 0, 0, 1);
        repeat (6) cyc(0, 0, 0, 0, 1);
        check("halt_done", 32'(done), 32'(1));
        mem[3] = 9'h004;
`endif

        // Asynchronous reset in the middle of a run with an instruction held
        cyc(0, 1, 0, 0, 1);
        cyc(1, 0, 0, 0, 1);
        repeat (3) cyc(0, 0, 0, 0, 1);
        check("pre_rst_vld", 32'(instr_valid), 32'(1));
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        cmp_all();
        @(negedge clk);
        rst_n = 1'b1;
        cyc(0, 0, 0, 0, 1);
        cyc(1, 0, 0, 0, 1);
        repeat (4) cyc(0, 0, 0, 0, 1);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/instr_fetch_ctrl.md
# instr_fetch_ctrl

Program-counter sequencer for the instruction memory. It owns the fetch address, walks it through the 9-bit program, and redirects it on branches. It presents each fetched instruction and its PC to decode through a valid/ready handshake, stalling on backpressure. It sits between the combinational instruction memory (addr in, instruction out) and the decode stage.

## Interface
Parameters:
- ADDR_WIDTH, 10, fetch address width; PC wraps modulo 2^ADDR_WIDTH
- DATA_WIDTH, 9, instruction width
- START_ADDR, 0, PC loaded on start

Ports:
- clk  in  1  clock; all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  pulse; begin fetching at START_ADDR
- stop  in  1  pulse; abort fetching, go HALTED
- branch_valid  in  1  redirect request, one-cycle
- branch_target  in  ADDR_WIDTH  absolute redirect address
- mem_addr  out  ADDR_WIDTH  address to instruction memory (= PC register)
- mem_instr  in  DATA_WIDTH  combinational read data for mem_addr
- instr_valid  out  1  output register holds an instruction
- instr_ready  in  1  decode accepts this cycle
- instr_data  out  DATA_WIDTH  fetched instruction
- instr_pc  out  ADDR_WIDTH  address instr_data came from
- busy  out  1  state == RUN
- done  out  1  state == HALTED
- pc_wrap  out  1  sticky: PC incremented past 2^ADDR_WIDTH-1

## Operation
- States: IDLE (after reset), RUN, HALTED.
- IDLE/HALTED + start -> RUN; PC <= START_ADDR; pc_wrap <= 0; output register emptied.
- start while in RUN: ignored.
- RUN, fetch condition: output register empty, or (instr_valid && instr_ready). On fetch: instr_data <= mem_instr; instr_pc <= PC; instr_valid <= 1; PC <= PC+1.
- RUN, stall (instr_valid && !instr_ready): PC, instr_data, instr_pc held stable.
- Branch (RUN, branch_valid): PC <= branch_target; instr_valid <= 0 (flush); no fetch that cycle. A same-cycle handshake counts as accepted by decode.
- stop (RUN): -> HALTED; instr_valid <= 0; PC held.
- Priority in RUN: stop > branch > fetch/stall.
- branch_valid and stop outside RUN: ignored.
- Wrap: PC 2^ADDR_WIDTH-1 increments to 0 and sets pc_wrap; fetching continues.
- HALTED: the output register is emptied on entry, so no instruction is held.

## Timing
- Reset values: mem_addr=START_ADDR, instr_valid=0, instr_data=0, instr_pc=0, busy=0, done=0, pc_wrap=0; state IDLE.
- start at edge T -> busy and mem_addr=START_ADDR after T; instr_valid=1 with mem[START_ADDR] after T+1.
- Throughput one instruction per cycle with instr_ready held high.
- Branch at edge T -> instr_valid=0 after T; instr_data=mem[target] valid after T+1 (one bubble).
- stop at edge T -> done=1, instr_valid=0 after T.
- rst_n assertion mid-RUN: immediate return to reset values regardless of clk.

## Configuration
- FETCH_HALT_OPCODE_EN defined:
  - Fetching 9'h1FF (all ones) does not load the output register. It moves the FSM to HALTED the next edge; PC is left pointing at the halt word.
  - An instruction already held in the output register is discarded, as with stop.
- FETCH_HALT_OPCODE_EN undefined: 9'h1FF is an ordinary instruction; only stop halts.

## Structure
- Package fetch_pkg:
  - typedef enum logic [1:0] fetch_state_e {FETCH_IDLE, FETCH_RUN, FETCH_HALTED}
  - localparam HALT_OPCODE = 9'h1FF
- One sub-module, fetch_out_reg: the output register with valid/ready, flush, and data/PC hold. The FSM and PC logic stay in instr_fetch_ctrl.
- The instruction memory is instantiated by the parent, not here.

## Test plan
- Reset then start, instr_ready=1, memory words 0..4 = 9'h001..9'h005 -> instr_data 001..005 on consecutive cycles; instr_pc 0..4; first valid two edges after start.
- Hold instr_ready=0 for 3 cycles at PC 2 -> instr_data/instr_pc frozen at mem[2]/2; mem_addr frozen at 3; resume yields mem[3] next.
- branch_valid with target 10'h200 while instr_valid&&instr_ready -> one bubble (instr_valid=0), then instr_pc=10'h200, 10'h201 back-to-back.
- Run from START_ADDR=10'h3FE -> instr_pc 3FE, 3FF, 000; pc_wrap rises with the 3FF->0 increment and stays high until the next start.
- stop and branch_valid in the same cycle -> done=1, instr_valid=0, mem_addr unchanged. With FETCH_HALT_OPCODE_EN, word 3 = 9'h1FF -> words 0..2 delivered, then done=1; 9'h1FF is never presented.
- Assert rst_n low mid-RUN with instr_valid=1 -> all outputs at reset values before the next clk edge; start afterwards restarts cleanly.
